// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor elevator controller with latched calls and SCAN scheduling
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  door_close,
    output logic                  dir_up,
    output logic [2:0]            state
);

    localparam int TRV_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TRV_W-1:0]  TRV_LAST  = TRV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE_UP    = 3'd1,
        S_MOVE_DOWN  = 3'd2,
        S_DOOR_OPEN  = 3'd3,
        S_DOOR_CLOSE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      current_floor_q, current_floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    dir_up_q, dir_up_d;
    logic [TRV_W-1:0]        travel_cnt_q, travel_cnt_d;
    logic [DOOR_W-1:0]       door_cnt_q, door_cnt_d;

    logic [NUM_FLOORS-1:0]   cur_onehot;
    logic [NUM_FLOORS-1:0]   call_mask;
    logic [NUM_FLOORS-1:0]   clr;
    logic [FLOOR_W-1:0]      floor_up;
    logic [FLOOR_W-1:0]      floor_dn;
    logic                    above;
    logic                    below;

    assign cur_onehot = NUM_FLOORS'(1) << current_floor_q;
    assign floor_up   = current_floor_q + FLOOR_W'(1);
    assign floor_dn   = current_floor_q - FLOOR_W'(1);

    // Outstanding calls strictly above and strictly below the car
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > current_floor_q) above = above | pending_q[i];
            if (FLOOR_W'(i) < current_floor_q) below = below | pending_q[i];
        end
    end

    // Next-state, position, timers and the set of calls served on this edge
    always_comb begin
        state_d         = state_q;
        current_floor_d = current_floor_q;
        dir_up_d        = dir_up_q;
        travel_cnt_d    = travel_cnt_q;
        door_cnt_d      = door_cnt_q;
        clr             = '0;

        case (state_q)
            S_IDLE: begin
                if (pending_q[current_floor_q]) begin
                    state_d    = S_DOOR_OPEN;
                    door_cnt_d = '0;
                    clr        = cur_onehot;
                end else if (dir_up_q && above) begin
                    state_d      = S_MOVE_UP;
                    travel_cnt_d = '0;
                end else if (!dir_up_q && below) begin
                    state_d      = S_MOVE_DOWN;
                    travel_cnt_d = '0;
                end else if (above) begin
                    state_d      = S_MOVE_UP;
                    travel_cnt_d = '0;
                    dir_up_d     = 1'b1;
                end else if (below) begin
                    state_d      = S_MOVE_DOWN;
                    travel_cnt_d = '0;
                    dir_up_d     = 1'b0;
                end
            end

            S_MOVE_UP: begin
                if (travel_cnt_q == TRV_LAST) begin
                    travel_cnt_d    = '0;
                    current_floor_d = floor_up;
                    if (pending_q[floor_up]) begin
                        state_d    = S_DOOR_OPEN;
                        door_cnt_d = '0;
                        clr        = NUM_FLOORS'(1) << floor_up;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TRV_W'(1);
                end
            end

            S_MOVE_DOWN: begin
                if (travel_cnt_q == TRV_LAST) begin
                    travel_cnt_d    = '0;
                    current_floor_d = floor_dn;
                    if (pending_q[floor_dn]) begin
                        state_d    = S_DOOR_OPEN;
                        door_cnt_d = '0;
                        clr        = NUM_FLOORS'(1) << floor_dn;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TRV_W'(1);
                end
            end

            S_DOOR_OPEN: begin
                // A hold or a fresh call at this floor keeps the door open longer
                if (door_hold || call_req[current_floor_q]) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = S_DOOR_CLOSE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_W'(1);
                end
            end

            S_DOOR_CLOSE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Calls for the floor whose door is open are already served, so never latch them
    always_comb begin
        call_mask = (state_q == S_DOOR_OPEN) ? cur_onehot : '0;
        pending_d = (pending_q | (call_req & ~call_mask)) & ~clr;
    end

    // State, position, call register and timers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            current_floor_q <= '0;
            pending_q       <= '0;
            dir_up_q        <= 1'b1;
            travel_cnt_q    <= '0;
            door_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            current_floor_q <= current_floor_d;
            pending_q       <= pending_d;
            dir_up_q        <= dir_up_d;
            travel_cnt_q    <= travel_cnt_d;
            door_cnt_q      <= door_cnt_d;
        end
    end

    // The car must never be driven past the end floors
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q == S_MOVE_UP && current_floor_q == FLOOR_W'(NUM_FLOORS - 1)));
            assert (!(state_q == S_MOVE_DOWN && current_floor_q == '0));
        end
    end

    assign current_floor = current_floor_q;
    assign pending       = pending_q;
    assign dir_up        = dir_up_q;
    assign state         = state_q;
    assign motor_up      = (state_q == S_MOVE_UP);
    assign motor_down    = (state_q == S_MOVE_DOWN);
    assign door_open     = (state_q == S_DOOR_OPEN);
    assign door_close    = (state_q == S_DOOR_CLOSE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed self-checking bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_UP    = 3'd1;
    localparam logic [2:0] ST_DOWN  = 3'd2;
    localparam logic [2:0] ST_OPEN  = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] call_req;
    logic       door_hold;
    logic [2:0] current_floor;
    logic [7:0] pending;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       door_close;
    logic       dir_up;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_scan_ctrl #(
        .NUM_FLOORS    (8),
        .FLOOR_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_req      (call_req),
        .door_hold     (door_hold),
        .current_floor (current_floor),
        .pending       (pending),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .door_close    (door_close),
        .dir_up        (dir_up),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_call(input logic [7:0] v);
        call_req = v;
        tick();
        call_req = '0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state !== s && n < max) begin
            tick();
            n++;
        end
        check(tag, state, s);
    endtask

    initial begin
        int mu_cnt;
        int do_cnt;
        int len;
        int nstops;
        int stops[4];
        logic motor_seen;
        logic down_seen;
        logic prev_open;
        logic stop_dir;
        logic [7:0] pend_or;

        rst       = 1'b1;
        call_req  = '0;
        door_hold = 1'b0;
        tick();
        tick();
        check("rst_state", state, ST_IDLE);
        check("rst_floor", current_floor, 0);
        check("rst_pending", pending, 0);
        check("rst_dir", dir_up, 1);
        check("rst_outs", {motor_up, motor_down, door_open, door_close}, 0);
        rst = 1'b0;

        // Floor 0 -> 3, cycle-exact
        pulse_call(8'h08);
        check("a_t1_state", state, ST_IDLE);
        check("a_t1_pending", pending, 8'h08);
        mu_cnt = 0;
        do_cnt = 0;
        for (int k = 2; k <= 20; k++) begin
            tick();
            if (motor_up)  mu_cnt++;
            if (door_open) do_cnt++;
            if (k == 2)  check("a_t2_up", state, ST_UP);
            if (k == 13) check("a_t13_up", state, ST_UP);
            if (k == 14) check("a_t14_open", {current_floor, state}, {3'd3, ST_OPEN});
            if (k == 18) check("a_t18_open", door_open, 1);
            if (k == 19) check("a_t19_close", door_close, 1);
            if (k == 20) check("a_t20_idle", {pending, 5'd0, state}, {8'h00, 5'd0, ST_IDLE});
        end
        check("a_motor_cycles", mu_cnt, 12);
        check("a_door_cycles", do_cnt, 5);

        // Floor 3 -> 2 to set up the at-floor tests
        pulse_call(8'h04);
        wait_state(ST_CLOSE, 100, "b_close");
        tick();
        check("b_arrive", {current_floor, state}, {3'd2, ST_IDLE});
        check("b_dir", dir_up, 0);

        // Call at the current floor: door only, no motion
        pulse_call(8'h04);
        check("c_t1_state", state, ST_IDLE);
        motor_seen = motor_up | motor_down;
        tick();
        check("c_t2_open", state, ST_OPEN);
        check("c_t2_pending", pending, 0);
        len = 0;
        pend_or = '0;
        while (door_open && len < 50) begin
            len++;
            pend_or = pend_or | pending;
            motor_seen = motor_seen | motor_up | motor_down;
            tick();
        end
        check("c_open_len", len, 5);
        check("c_pending_or", pend_or, 0);
        check("c_close", door_close, 1);
        tick();
        check("c_idle", state, ST_IDLE);
        check("c_no_motor", motor_seen, 0);

        // door_hold for 10 cycles from door-open entry
        pulse_call(8'h04);
        tick();
        check("d_open", state, ST_OPEN);
        door_hold = 1'b1;
        len = 0;
        while (door_open && len < 50) begin
            len++;
            tick();
            if (len == 10) door_hold = 1'b0;
        end
        door_hold = 1'b0;
        check("d_open_len", len, 15);
        wait_state(ST_IDLE, 10, "d_idle");

        // Call for this floor while open restarts the count and is not latched
        pulse_call(8'h04);
        tick();
        check("e_open", state, ST_OPEN);
        len = 0;
        pend_or = '0;
        while (door_open && len < 50) begin
            len++;
            pend_or = pend_or | pending;
            tick();
            call_req = (len == 2) ? 8'h04 : 8'h00;
        end
        call_req = '0;
        check("e_open_len", len, 8);
        check("e_pending_or", pend_or, 0);
        wait_state(ST_IDLE, 10, "e_idle");

        // SCAN: going up to 5, call for 1 added while passing 3
        pulse_call(8'h20);
        len = 0;
        while (!(state == ST_UP && current_floor == 3'd3) && len < 100) begin
            tick();
            len++;
        end
        check("f_reach3", (state == ST_UP && current_floor == 3'd3), 1);
        call_req = 8'h02;
        tick();
        call_req = '0;
        nstops = 0;
        prev_open = 1'b0;
        down_seen = 1'b0;
        stop_dir = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (door_open && !prev_open && nstops < 4) begin
                stops[nstops] = int'(current_floor);
                nstops++;
                stop_dir = dir_up;
            end
            prev_open = door_open;
            down_seen = down_seen | motor_down;
            if (nstops == 2 && state == ST_IDLE) break;
            tick();
        end
        check("f_nstops", nstops, 2);
        check("f_stop0", stops[0], 5);
        check("f_stop1", stops[1], 1);
        check("f_dir_at_1", stop_dir, 0);
        check("f_down_seen", down_seen, 1);
        check("f_pending_end", pending, 0);

        // Reset in mid-travel drops everything
        pulse_call(8'hC0);
        wait_state(ST_UP, 10, "g_up");
        tick();
        tick();
        tick();
        check("g_pending_before", pending, 8'hC0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("g_state", state, ST_IDLE);
        check("g_floor", current_floor, 0);
        check("g_pending", pending, 0);
        check("g_dir", dir_up, 1);
        check("g_motor", motor_up, 0);
        tick();
        tick();
        check("g_stay_idle", state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
